// File: rtl/led_drv_defs.sv
// Shared definitions for the LED shift-register driver: FSM state encoding and
// default timing parameters.
package led_drv_defs;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StShiftLo = 2'd1,
        StShiftHi = 2'd2,
        StLatch   = 2'd3
    } led_state_e;

    localparam int unsigned N_LED_DEFAULT       = 9;
    localparam int unsigned CLK_DIV_DEFAULT     = 4;
    localparam int unsigned REFRESH_CYC_DEFAULT = 1000000;

    // Number of clk cycles busy stays high for one frame.
    function automatic int unsigned frame_cycles(input int unsigned n_led,
                                                 input int unsigned clk_div);
        return 2 * clk_div * n_led + clk_div;
    endfunction

endpackage

// File: rtl/led_div_tick.sv
// Phase timer: counts 0..CLK_DIV-1 and strobes tick on the last count of each phase.
module led_div_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick = (cnt_q == CntW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_reg_driver.sv
// Serialises the LED level vector to a 74HC595-style chain, resending on change,
// on request, or after a refresh timeout.
module led_shift_reg_driver
    import led_drv_defs::*;
#(
    parameter int unsigned N_LED       = N_LED_DEFAULT,
    parameter int unsigned CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int unsigned REFRESH_CYC = REFRESH_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_LED-1:0] led_in,
    input  logic             refresh_req,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             sr_latch,
    output logic             sr_oe_n,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned IdxW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int unsigned RefW = $clog2(REFRESH_CYC);

    led_state_e       state_q, state_d;
    logic [N_LED-1:0] snap_q, snap_d;
    logic [N_LED-1:0] last_q, last_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [RefW-1:0]  ref_q, ref_d;
    logic             sr_data_q, sr_data_d;
    logic             sr_clk_q, sr_clk_d;
    logic             sr_latch_q, sr_latch_d;
    logic             oe_n_q, oe_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic div_clr;
    logic div_tick;
    logic trigger;

    led_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (div_tick)
    );

    assign trigger = refresh_req || (led_in != last_q) || (ref_q == RefW'(REFRESH_CYC - 1));

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        last_d     = last_q;
        idx_d      = idx_q;
        ref_d      = ref_q;
        sr_data_d  = sr_data_q;
        sr_clk_d   = sr_clk_q;
        sr_latch_d = sr_latch_q;
        oe_n_d     = oe_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Divider held at zero so the first low phase is a full CLK_DIV long.
                div_clr = 1'b1;
                if (trigger) begin
                    snap_d    = led_in;
                    last_d    = led_in;
                    idx_d     = IdxW'(N_LED - 1);
                    ref_d     = '0;
                    sr_data_d = led_in[N_LED-1];
                    sr_clk_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StShiftLo;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
            StShiftLo: begin
                if (div_tick) begin
                    div_clr  = 1'b1;
                    sr_clk_d = 1'b1;
                    state_d  = StShiftHi;
                end
            end
            StShiftHi: begin
                if (div_tick) begin
                    div_clr  = 1'b1;
                    sr_clk_d = 1'b0;
                    if (idx_q == '0) begin
                        sr_data_d  = 1'b0;
                        sr_latch_d = 1'b1;
                        state_d    = StLatch;
                    end else begin
                        idx_d     = idx_q - 1'b1;
                        sr_data_d = snap_q[idx_q - 1'b1];
                        state_d   = StShiftLo;
                    end
                end
            end
            StLatch: begin
                if (div_tick) begin
                    div_clr    = 1'b1;
                    sr_latch_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    oe_n_d     = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            snap_q     <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            ref_q      <= '0;
            sr_data_q  <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_latch_q <= 1'b0;
            oe_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            ref_q      <= ref_d;
            sr_data_q  <= sr_data_d;
            sr_clk_q   <= sr_clk_d;
            sr_latch_q <= sr_latch_d;
            oe_n_q     <= oe_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sr_data    = sr_data_q;
    assign sr_clk     = sr_clk_q;
    assign sr_latch   = sr_latch_q;
    assign sr_oe_n    = oe_n_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_led_shift_reg_driver.sv
// Bench for led_shift_reg_driver: an external 74HC595 chain model observes the serial
// pins and the latched value is compared against what the bench drove.
module tb_led_shift_reg_driver;

    localparam int unsigned N     = 9;
    localparam int unsigned DIV   = 2;
    localparam int unsigned REF   = 50;
    localparam int unsigned FRAME = 2 * DIV * N + DIV;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] led_in;
    logic         refresh_req;
    logic         sr_data, sr_clk, sr_latch, sr_oe_n, busy, frame_done;

    led_shift_reg_driver #(
        .N_LED       (N),
        .CLK_DIV     (DIV),
        .REFRESH_CYC (REF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_in      (led_in),
        .refresh_req (refresh_req),
        .sr_data     (sr_data),
        .sr_clk      (sr_clk),
        .sr_latch    (sr_latch),
        .sr_oe_n     (sr_oe_n),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift-register chain model plus frame statistics, sampled on the falling edge.
    logic [N-1:0] chain_sr = '0;
    logic [N-1:0] chain_out = '0;
    int rises_frame = 0, rises_at_latch = 0, latch_cnt = 0, done_cnt = 0;
    int latch_w_cur = 0, latch_w_last = 0, busy_cur = 0, busy_len_last = 0, glitch_cnt = 0;

    initial begin
        logic p_clk, p_latch, p_busy, p_data;
        p_clk = 1'b0; p_latch = 1'b0; p_busy = 1'b0; p_data = 1'b0;
        forever begin
            @(negedge clk);
            if (sr_clk && !p_clk) begin
                chain_sr = {chain_sr[N-2:0], sr_data};
                rises_frame++;
            end
            if (sr_clk && p_clk && sr_data !== p_data) glitch_cnt++;
            if (sr_latch && sr_data) glitch_cnt++;
            if (sr_latch && !p_latch) begin
                chain_out = chain_sr;
                latch_cnt++;
                rises_at_latch = rises_frame;
            end
            if (sr_latch) latch_w_cur++;
            else if (p_latch) begin
                latch_w_last = latch_w_cur;
                latch_w_cur = 0;
            end
            if (busy && !p_busy) begin
                rises_frame = 0;
                busy_cur = 0;
            end
            if (busy) busy_cur++;
            else if (p_busy) busy_len_last = busy_cur;
            if (frame_done) done_cnt++;
            p_clk = sr_clk; p_latch = sr_latch; p_busy = busy; p_data = sr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_busy_timeout"}, 32'(n < 200), 32'd1);
    endtask

    // Returns one cycle after the frame_done cycle so the monitor has seen the frame end.
    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check_eq({tag, "_done_timeout"}, 32'(n < 2000), 32'd1);
        step();
    endtask

    task automatic check_frame(input string tag, input logic [N-1:0] exp);
        check_eq({tag, "_latched"}, 32'(chain_out), 32'(exp));
        check_eq({tag, "_rises"}, rises_at_latch, N);
        check_eq({tag, "_latch_w"}, latch_w_last, DIV);
        check_eq({tag, "_busy_len"}, busy_len_last, FRAME);
        check_eq({tag, "_oe_n"}, 32'(sr_oe_n), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sr_data"}, 32'(sr_data), 32'd0);
        check_eq({tag, "_sr_clk"}, 32'(sr_clk), 32'd0);
        check_eq({tag, "_sr_latch"}, 32'(sr_latch), 32'd0);
        check_eq({tag, "_sr_oe_n"}, 32'(sr_oe_n), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    function automatic logic [N-1:0] rand_diff(input logic [N-1:0] avoid);
        logic [N-1:0] r;
        do begin
            r = N'($urandom);
        end while (r == avoid || r == '0);
        return r;
    endfunction

    initial begin
        logic [N-1:0] v, w, r;
        int cnt, n;

        rst = 1'b1; led_in = '0; refresh_req = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs("rst");

        // Refresh timeout alone starts the first frame.
        repeat (REF - 1) step();
        check_eq("refresh_early", 32'(busy), 32'd0);
        step();
        check_eq("refresh_start", 32'(busy), 32'd1);
        wait_done("f1");
        check_frame("f1", '0);
        check_eq("f1_done_cnt", done_cnt, 1);
        check_eq("f1_done_pulse", 32'(frame_done), 32'd0);

        led_in = 9'h1A5;
        wait_done("f2");
        check_frame("f2", 9'h1A5);

        // Mid-frame change: current frame keeps its snapshot, next follows with no gap.
        led_in = 9'h001;
        wait_busy("f3");
        repeat (10) step();
        led_in = 9'h100;
        wait_done("f3");
        check_frame("f3", 9'h001);
        check_eq("no_dead_cycle", 32'(busy), 32'd1);
        wait_done("f4");
        check_frame("f4", 9'h100);

        // refresh_req while busy is dropped.
        v = rand_diff(9'h100);
        led_in = v;
        wait_busy("f5");
        repeat (5) step();
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
        wait_done("f5");
        check_frame("f5", v);
        cnt = latch_cnt;
        repeat (20) step();
        check_eq("busy_req_ignored", latch_cnt, cnt);
        check_eq("busy_req_idle", 32'(busy), 32'd0);

        // refresh_req in idle resends the same value exactly once.
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
        wait_done("f6");
        check_eq("req_one_frame", latch_cnt, cnt + 1);
        check_frame("f6", v);
        repeat (20) step();
        check_eq("req_no_extra", latch_cnt, cnt + 1);

        // Reset after five shift clocks: blanked, partial frame never latched.
        w = rand_diff(v);
        led_in = w;
        wait_busy("f7");
        n = 0;
        while (rises_frame < 5 && n < 200) begin
            step();
            n++;
        end
        check_eq("f7_rise_timeout", 32'(n < 200), 32'd1);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        cnt = latch_cnt;
        check_eq("midrst_keep", 32'(chain_out), 32'(v));
        wait_busy("f8");
        repeat (3) step();
        check_eq("midrst_blank", 32'(sr_oe_n), 32'd1);
        wait_done("f8");
        check_eq("midrst_one_latch", latch_cnt, cnt + 1);
        check_frame("f8", w);

        for (int i = 0; i < 6; i++) begin
            r = rand_diff(led_in);
            led_in = r;
            wait_done("rnd");
            check_frame("rnd", r);
        end

        check_eq("glitch", glitch_cnt, 0);
        check_eq("done_per_latch", done_cnt, latch_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
